add_sub_df: RTL and testbench

ADD_SUB_DF -- requirements
Module: add_sub_df

---
 rtl/add_sub_pkg.sv | 5 +
 rtl/full_adder.sv | 11 +
 rtl/add_sub_df.sv | 50 +++++
 tb/tb_add_sub_df.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// add_sub_pkg: shared default width and add/subtract mode encoding for add_sub_df
package add_sub_pkg;
  localparam int WIDTH_DEFAULT = 4;
  typedef enum logic {ADD = 1'b0, SUB = 1'b1} mode_e;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder (a, b, ci -> s, co), the carry-chain cell of add_sub_df
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/add_sub_df.sv
// add_sub_df: registered ripple-carry add/sub (clk, rst_n, A, B, Cin 0=add/1=sub, in_valid -> R, Cout, out_valid; V/Z when ADD_SUB_DF_FLAGS_EN)
module add_sub_df
  import add_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] R,
  output logic             Cout,
  output logic             out_valid
`ifdef ADD_SUB_DF_FLAGS_EN
  ,
  output logic             V,
  output logic             Z
`endif
);
  logic             inv;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  assign inv = (mode_e'(Cin) == SUB);
  assign c[0] = inv;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder fa (.a(A[i]), .b(B[i] ^ inv), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      R <= '0;
      Cout <= 1'b0;
      out_valid <= 1'b0;
`ifdef ADD_SUB_DF_FLAGS_EN
      V <= 1'b0;
      Z <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        R <= s;
        Cout <= c[WIDTH];
`ifdef ADD_SUB_DF_FLAGS_EN
        V <= c[WIDTH] ^ c[WIDTH-1];
        Z <= ~|s;
`endif
      end
    end
endmodule

// File: tb/tb_add_sub_df.sv
// tb_add_sub_df: directed-vector scoreboard bench for add_sub_df at WIDTH=4
module tb_add_sub_df;
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] r;
    logic       co;
    logic       v;
    logic       z;
  } vec_t;
  typedef struct packed {
    logic [3:0] r;
    logic       co;
    logic       v;
    logic       z;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic       Cin = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] R;
  logic       Cout;
  logic       out_valid;
`ifdef ADD_SUB_DF_FLAGS_EN
  logic       V;
  logic       Z;
`endif
  int errors = 0;
  int checks = 0;
  exp_t q[$];
  vec_t vecs[11] = '{
    '{4'b0001, 4'b0011, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0},
    '{4'b1010, 4'b1100, 1'b0, 4'b0110, 1'b1, 1'b1, 1'b0},
    '{4'b0101, 4'b0110, 1'b0, 4'b1011, 1'b0, 1'b1, 1'b0},
    '{4'b0101, 4'b0010, 1'b1, 4'b0011, 1'b1, 1'b0, 1'b0},
    '{4'b1111, 4'b0110, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0},
    '{4'b0011, 4'b0011, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1},
    '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0},
    '{4'b0000, 4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0},
    '{4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1, 1'b0},
    '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1},
    '{4'b1010, 4'b1100, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0}
  };
  add_sub_df #(.WIDTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .A(A),
    .B(B),
    .Cin(Cin),
    .in_valid(in_valid),
    .R(R),
    .Cout(Cout),
    .out_valid(out_valid)
`ifdef ADD_SUB_DF_FLAGS_EN
    ,
    .V(V),
    .Z(Z)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic issue(input vec_t t, input bit push);
    @(posedge clk);
    #1;
    A = t.a;
    B = t.b;
    Cin = t.cin;
    in_valid = 1'b1;
    if (push) q.push_back('{t.r, t.co, t.v, t.z});
  endtask
  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 4'b0110;
    B = 4'b1001;
    Cin = ~Cin;
  endtask
  always @(negedge clk)
    if (out_valid) begin
      if (q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("R", 32'(R), 32'(e.r));
        chk("Cout", 32'(Cout), 32'(e.co));
`ifdef ADD_SUB_DF_FLAGS_EN
        chk("V", 32'(V), 32'(e.v));
        chk("Z", 32'(Z), 32'(e.z));
`endif
      end
    end
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("reset_R", 32'(R), 32'd0);
    chk("reset_Cout", 32'(Cout), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    foreach (vecs[i]) issue(vecs[i], 1'b1);
    idle();
    repeat (3) begin
      @(posedge clk);
      #2;
      chk("hold_out_valid", 32'(out_valid), 32'd0);
      chk("hold_R", 32'(R), 32'(vecs[10].r));
      chk("hold_Cout", 32'(Cout), 32'(vecs[10].co));
    end
    drain();
    issue('{4'b0101, 4'b0110, 1'b0, 4'b1011, 1'b0, 1'b1, 1'b0}, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_R", 32'(R), 32'd0);
    chk("async_Cout", 32'(Cout), 32'd0);
    chk("async_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("in_reset_R", 32'(R), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("post_reset_out_valid", 32'(out_valid), 32'd0);
    chk("post_reset_R", 32'(R), 32'd0);
    issue(vecs[4], 1'b1);
    idle();
    drain();
    @(posedge clk);
    #2;
    chk("resume_R", 32'(R), 32'(vecs[4].r));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
